// File: rtl/prewitt_stream.sv
`default_nettype none
// ============================================================================
// Module   : prewitt_stream
// Purpose  : Streaming 3x3 Prewitt edge detector for raster-order pixels.
//            Two line buffers plus a 3x3 window; selectable horizontal,
//            vertical or combined magnitude; saturating output; border
//            outputs forced to zero.
// Ports    : clk        rising-edge clock
//            rst        asynchronous, active-low reset
//            mode       00 horiz |sum_x|, 01 vert |sum_y|, 1x both
//            in_valid / in_ready / in_pixel   input pixel handshake
//            out_valid / out_pixel            one beat per output pixel
//            frame_done pulse with the last output pixel of a frame
//            thresh     binarisation threshold (PREWITT_THRESH_EN only)
// Options  : define PREWITT_THRESH_EN to binarise the interior output.
// Revision : 1.0 - initial release
// ============================================================================
module prewitt_stream #(
  parameter int ROWS  = 242,
  parameter int COLS  = 247,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             out_valid,
  output logic [PIX_W-1:0] out_pixel,
  output logic             frame_done
`ifdef PREWITT_THRESH_EN
  ,
  input  logic [PIX_W-1:0] thresh
`endif
);

  localparam int NPIX  = ROWS * COLS;
  localparam int CNT_W = $clog2(NPIX + 1);
  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);
  localparam int SUM_W = PIX_W + 3;
  localparam int MAG_W = PIX_W + 4;
  localparam logic [MAG_W-1:0] SAT_MAX = {{4{1'b0}}, {PIX_W{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [COL_W-1:0] in_col_q, in_col_d;
  logic [COL_W-1:0] out_col_q, out_col_d;
  logic [ROW_W-1:0] out_row_q, out_row_d;
  // Window: left (l) and middle (m) columns; the right column is the
  // incoming one, so the result is available on the accepting edge.
  logic [PIX_W-1:0] wl_t_q, wl_m_q, wl_b_q, wl_t_d, wl_m_d, wl_b_d;
  logic [PIX_W-1:0] wm_t_q, wm_m_q, wm_b_q, wm_t_d, wm_m_d, wm_b_d;
  logic             out_valid_q, out_valid_d;
  logic [PIX_W-1:0] out_pixel_q, out_pixel_d;
  logic             frame_done_q, frame_done_d;

  // Line buffers: lb_top holds row r-2, lb_mid holds row r-1 per column.
  logic [PIX_W-1:0] lb_top_q [COLS];
  logic [PIX_W-1:0] lb_mid_q [COLS];

  logic             accept, flush_step, step, emit, last_out, interior;
  logic [PIX_W-1:0] new_t, new_m, new_b;
  logic [SUM_W-1:0] col_l, col_r, row_t, row_b, diff_x, diff_y, neg_x, neg_y;
  logic [MAG_W-1:0] abs_x, abs_y, mag;
  logic [PIX_W-1:0] sat_pix, res_pix;

  assign in_ready   = (state_q != S_FLUSH);
  assign accept     = in_valid && in_ready;
  assign flush_step = (state_q == S_FLUSH);
  assign step       = accept || flush_step;
  // Outputs start once the window can be centred on raster index 0.
  assign emit       = flush_step || (accept && (pix_cnt_q >= CNT_W'(COLS + 1)));
  assign last_out   = (out_row_q == ROW_W'(ROWS - 1)) && (out_col_q == COL_W'(COLS - 1));
  assign interior   = (out_row_q != '0) && (out_row_q != ROW_W'(ROWS - 1)) &&
                      (out_col_q != '0) && (out_col_q != COL_W'(COLS - 1));

  // Flush feeds zero-valued virtual pixels; they only reach border outputs.
  assign new_b = flush_step ? '0 : in_pixel;
  assign new_m = lb_mid_q[in_col_q];
  assign new_t = lb_top_q[in_col_q];

  always_comb begin
    col_l  = SUM_W'(wl_t_q) + SUM_W'(wl_m_q) + SUM_W'(wl_b_q);
    col_r  = SUM_W'(new_t)  + SUM_W'(new_m)  + SUM_W'(new_b);
    row_t  = SUM_W'(wl_t_q) + SUM_W'(wm_t_q) + SUM_W'(new_t);
    row_b  = SUM_W'(wl_b_q) + SUM_W'(wm_b_q) + SUM_W'(new_b);
    diff_x = col_l - col_r;
    diff_y = row_t - row_b;
    neg_x  = -diff_x;
    neg_y  = -diff_y;
    abs_x  = {1'b0, (diff_x[SUM_W-1] ? neg_x : diff_x)};
    abs_y  = {1'b0, (diff_y[SUM_W-1] ? neg_y : diff_y)};
    case (mode_q)
      2'b00:   mag = abs_x;
      2'b01:   mag = abs_y;
      default: mag = abs_x + abs_y;
    endcase
    sat_pix = (mag > SAT_MAX) ? {PIX_W{1'b1}} : mag[PIX_W-1:0];
`ifdef PREWITT_THRESH_EN
    res_pix = (sat_pix >= thresh) ? {PIX_W{1'b1}} : '0;
`else
    res_pix = sat_pix;
`endif
  end

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    pix_cnt_d    = pix_cnt_q;
    in_col_d     = in_col_q;
    out_col_d    = out_col_q;
    out_row_d    = out_row_q;
    wl_t_d       = wl_t_q;
    wl_m_d       = wl_m_q;
    wl_b_d       = wl_b_q;
    wm_t_d       = wm_t_q;
    wm_m_d       = wm_m_q;
    wm_b_d       = wm_b_q;
    out_valid_d  = 1'b0;
    out_pixel_d  = '0;
    frame_done_d = 1'b0;

    if (step) begin
      wl_t_d   = wm_t_q;
      wl_m_d   = wm_m_q;
      wl_b_d   = wm_b_q;
      wm_t_d   = new_t;
      wm_m_d   = new_m;
      wm_b_d   = new_b;
      in_col_d = (in_col_q == COL_W'(COLS - 1)) ? '0 : in_col_q + 1'b1;
    end

    if (accept) begin
      pix_cnt_d = pix_cnt_q + 1'b1;
      if (state_q == S_IDLE) begin
        mode_d  = mode;
        state_d = S_RUN;
      end
      if (pix_cnt_q == CNT_W'(NPIX - 1)) begin
        state_d = S_FLUSH;
      end
    end

    if (emit) begin
      out_valid_d = 1'b1;
      out_pixel_d = interior ? res_pix : '0;
      if (out_col_q == COL_W'(COLS - 1)) begin
        out_col_d = '0;
        out_row_d = out_row_q + 1'b1;
      end else begin
        out_col_d = out_col_q + 1'b1;
      end
      // The final output always falls inside FLUSH.
      if (last_out) begin
        frame_done_d = 1'b1;
        state_d      = S_IDLE;
        pix_cnt_d    = '0;
        in_col_d     = '0;
        out_col_d    = '0;
        out_row_d    = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      mode_q       <= 2'b00;
      pix_cnt_q    <= '0;
      in_col_q     <= '0;
      out_col_q    <= '0;
      out_row_q    <= '0;
      wl_t_q       <= '0;
      wl_m_q       <= '0;
      wl_b_q       <= '0;
      wm_t_q       <= '0;
      wm_m_q       <= '0;
      wm_b_q       <= '0;
      out_valid_q  <= 1'b0;
      out_pixel_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      pix_cnt_q    <= pix_cnt_d;
      in_col_q     <= in_col_d;
      out_col_q    <= out_col_d;
      out_row_q    <= out_row_d;
      wl_t_q       <= wl_t_d;
      wl_m_q       <= wl_m_d;
      wl_b_q       <= wl_b_d;
      wm_t_q       <= wm_t_d;
      wm_m_q       <= wm_m_d;
      wm_b_q       <= wm_b_d;
      out_valid_q  <= out_valid_d;
      out_pixel_q  <= out_pixel_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffer storage needs no reset: stale contents only reach borders.
  always_ff @(posedge clk) begin
    if (step) begin
      lb_top_q[in_col_q] <= new_m;
      lb_mid_q[in_col_q] <= new_b;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_pixel  = out_pixel_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_prewitt_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_prewitt_stream
// Purpose  : Self-checking scoreboard bench for prewitt_stream (5x6, 8-bit).
//            Expected outputs are queued when a frame is driven and popped
//            as the DUT produces output beats.
// Options  : define PREWITT_THRESH_EN to exercise the threshold output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prewitt_stream;

  localparam int ROWS  = 5;
  localparam int COLS  = 6;
  localparam int PIX_W = 8;

  logic             clk      = 1'b0;
  logic             rst      = 1'b0;
  logic [1:0]       mode     = 2'b00;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [PIX_W-1:0] in_pixel = '0;
  logic             out_valid;
  logic [PIX_W-1:0] out_pixel;
  logic             frame_done;
`ifdef PREWITT_THRESH_EN
  logic [PIX_W-1:0] thresh = '0;
`endif

  int n_vec     = 0;
  int n_err     = 0;
  int ready_low = 0;
  bit sb_en     = 1'b1;

  typedef struct packed {
    logic [7:0] pix;
    logic       done;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  prewitt_stream #(.ROWS(ROWS), .COLS(COLS), .PIX_W(PIX_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pixel   (in_pixel),
    .out_valid  (out_valid),
    .out_pixel  (out_pixel),
    .frame_done (frame_done)
`ifdef PREWITT_THRESH_EN
    ,
    .thresh     (thresh)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  // Test images: 0 flat, 1 vertical step, 2 horizontal step, 3 ramp.
  function automatic int pix_val(input int pat, input int r, input int c);
    case (pat)
      0:       return 100;
      1:       return (c >= 3) ? 200 : 0;
      2:       return (r >= 2) ? 200 : 0;
      default: return 10 * c + 5 * r;
    endcase
  endfunction

  function automatic int exp_pix(input int pat, input logic [1:0] md, input int r, input int c);
    int sx, sy, m;
    sx = 0;
    sy = 0;
    if (r == 0 || r == ROWS - 1 || c == 0 || c == COLS - 1) return 0;
    for (int d = -1; d <= 1; d++) begin
      sx += pix_val(pat, r + d, c - 1) - pix_val(pat, r + d, c + 1);
      sy += pix_val(pat, r - 1, c + d) - pix_val(pat, r + 1, c + d);
    end
    if (sx < 0) sx = -sx;
    if (sy < 0) sy = -sy;
    case (md)
      2'b00:   m = sx;
      2'b01:   m = sy;
      default: m = sx + sy;
    endcase
    if (m > 255) m = 255;
`ifdef PREWITT_THRESH_EN
    m = (m >= int'(thresh)) ? 255 : 0;
`endif
    return m;
  endfunction

  // Output monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (!in_ready) ready_low++;
      if (out_valid && sb_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_pixel", 32'(out_pixel), 32'(e.pix));
          check("frame_done", 32'(frame_done), 32'(e.done));
        end
      end
      if (frame_done && (!out_valid || !sb_en)) check("stray_done", 32'd1, 32'd0);
    end
  end

  task automatic drive_pixel(input int p, input bit gap);
    int guard;
    if (gap) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_pixel = 8'(p);
    guard    = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int pat, input logic [1:0] md, input bit gaps,
                            input int toggle_at, input logic [1:0] md2);
    exp_t e;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        e.pix  = 8'(exp_pix(pat, md, r, c));
        e.done = (r == ROWS - 1) && (c == COLS - 1);
        exp_q.push_back(e);
      end
    end
    mode = md;
    for (int i = 0; i < ROWS * COLS; i++) begin
      if (i == toggle_at) mode = md2;
      drive_pixel(pix_val(pat, i / COLS, i % COLS), gaps && ($urandom_range(0, 2) == 0));
    end
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_pixel", 32'(out_pixel), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Flat image: all zero, in_ready low only during the COLS+1 flush cycles.
    ready_low = 0;
    send_frame(0, 2'b10, 1'b0, -1, 2'b00);
    wait_drain();
    check("flush_ready_low", 32'(ready_low), 32'(COLS + 1));

    // Step images and ramp in all modes, back to back.
    send_frame(1, 2'b00, 1'b0, -1, 2'b00);
    send_frame(1, 2'b01, 1'b0, -1, 2'b00);
    send_frame(2, 2'b01, 1'b0, -1, 2'b00);
    send_frame(3, 2'b00, 1'b0, -1, 2'b00);
    send_frame(3, 2'b01, 1'b0, -1, 2'b00);
    send_frame(3, 2'b10, 1'b0, -1, 2'b00);
    send_frame(3, 2'b11, 1'b0, -1, 2'b00);
    wait_drain();

    // Mid-frame mode change is ignored; next frame picks up the new mode.
    send_frame(3, 2'b10, 1'b0, 15, 2'b00);
    send_frame(3, 2'b00, 1'b0, -1, 2'b00);
    wait_drain();

    // Random input gaps.
    send_frame(3, 2'b10, 1'b1, -1, 2'b00);
    send_frame(1, 2'b00, 1'b1, -1, 2'b00);
    wait_drain();

    // Reset asserted at pixel 17 of a frame.
    sb_en = 1'b0;
    mode  = 2'b10;
    for (int i = 0; i < 17; i++) drive_pixel(pix_val(3, i / COLS, i % COLS), 1'b0);
    rst = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_frame_done", 32'(frame_done), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_pixel", 32'(out_pixel), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    sb_en = 1'b1;
    check("postrst_out_valid", 32'(out_valid), 32'd0);
    send_frame(3, 2'b10, 1'b0, -1, 2'b00);
    wait_drain();

`ifdef PREWITT_THRESH_EN
    thresh = 8'd70;
    send_frame(3, 2'b10, 1'b0, -1, 2'b00);
    wait_drain();
    thresh = 8'd91;
    send_frame(3, 2'b10, 1'b0, -1, 2'b00);
    wait_drain();
`endif

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
